// File: rtl/sb_ram40_4k_model_pkg.sv
// Shared definitions for the iCE40 4 Kbit block RAM model: aspect-mode encoding
// and the per-mode geometry lookups used by both ports.
package sb_ram40_4k_model_pkg;

   localparam int ARRAY_BITS  = 4096;
   localparam int DATA_BITS   = 16;
   localparam int ADDR_BITS   = 11;

   localparam int MODE_256X16 = 0;
   localparam int MODE_512X8  = 1;
   localparam int MODE_1024X4 = 2;
   localparam int MODE_2048X2 = 3;

   // Word width shrinks by half and depth doubles with each step of the mode.
   function automatic int mode_width(input int mode);
      return DATA_BITS >> mode;
   endfunction

   function automatic int mode_addr_bits(input int mode);
      return 8 + mode;
   endfunction

endpackage

// File: rtl/sb_ram40_4k_model_port_slice.sv
// Maps one port's address onto the linear bit array: base bit offset of the
// addressed word and which of the 16 data lanes take part in the access.
module sb_ram_port_slice
   import sb_ram40_4k_model_pkg::*;
#(
   parameter int MODE = MODE_256X16
) (
   input  logic [10:0] addr,
   input  logic [15:0] mask,
   output logic [11:0] offset,
   output logic [15:0] bit_en
);

   localparam int WIDTH = mode_width(MODE);
   localparam int ABITS = mode_addr_bits(MODE);
   localparam int SHIFT = 4 - MODE;
   localparam logic [10:0] ADDR_MASK = 11'((1 << ABITS) - 1);

   logic [11:0] word_addr;

   // Upper address bits are dropped so the address wraps modulo the mode depth;
   // the bit mask only matters in the 16-bit aspect.
   always_comb begin
      word_addr = {1'b0, addr & ADDR_MASK};
      offset    = word_addr << SHIFT;
      bit_en    = '0;
      for (int i = 0; i < DATA_BITS; i++) begin
         bit_en[i] = (i < WIDTH) && !((MODE == MODE_256X16) && mask[i]);
      end
   end

endmodule

// File: rtl/sb_ram40_4k_model.sv
// Behavioural single-clock iCE40 4 Kbit block RAM with independent read and
// write aspect ratios over one linear bit array and a registered read port.
module sb_ram40_4k_model
   import sb_ram40_4k_model_pkg::*;
#(
   parameter int READ_MODE  = MODE_256X16,
   parameter int WRITE_MODE = MODE_256X16,
   parameter logic [255:0] INIT_0 = 256'h0,
   parameter logic [255:0] INIT_1 = 256'h0,
   parameter logic [255:0] INIT_2 = 256'h0,
   parameter logic [255:0] INIT_3 = 256'h0,
   parameter logic [255:0] INIT_4 = 256'h0,
   parameter logic [255:0] INIT_5 = 256'h0,
   parameter logic [255:0] INIT_6 = 256'h0,
   parameter logic [255:0] INIT_7 = 256'h0,
   parameter logic [255:0] INIT_8 = 256'h0,
   parameter logic [255:0] INIT_9 = 256'h0,
   parameter logic [255:0] INIT_A = 256'h0,
   parameter logic [255:0] INIT_B = 256'h0,
   parameter logic [255:0] INIT_C = 256'h0,
   parameter logic [255:0] INIT_D = 256'h0,
   parameter logic [255:0] INIT_E = 256'h0,
   parameter logic [255:0] INIT_F = 256'h0
) (
   input  logic        CLK,
   input  logic        RST,
   output logic [15:0] RDATA,
   input  logic [10:0] RADDR,
   input  logic        RCLKE,
   input  logic        RE,
   input  logic [15:0] WDATA,
   input  logic [10:0] WADDR,
   input  logic        WCLKE,
   input  logic        WE,
   input  logic [15:0] MASK
);

   // Power-up contents come from INIT_*; reset never touches the array.
   logic [ARRAY_BITS-1:0] mem = {INIT_F, INIT_E, INIT_D, INIT_C, INIT_B, INIT_A, INIT_9, INIT_8,
                                 INIT_7, INIT_6, INIT_5, INIT_4, INIT_3, INIT_2, INIT_1, INIT_0};

   logic [11:0] rd_offset;
   logic [15:0] rd_bit_en;
   logic [11:0] wr_offset;
   logic [15:0] wr_bit_en;
   logic [15:0] rd_word;

   sb_ram_port_slice #(.MODE(READ_MODE)) u_rd_slice (
      .addr   (RADDR),
      .mask   (16'h0000),
      .offset (rd_offset),
      .bit_en (rd_bit_en)
   );

   sb_ram_port_slice #(.MODE(WRITE_MODE)) u_wr_slice (
      .addr   (WADDR),
      .mask   (MASK),
      .offset (wr_offset),
      .bit_en (wr_bit_en)
   );

   // Lanes above the read width come back as zero; the 12-bit index keeps
   // every lookup inside the array.
   always_comb begin
      rd_word = '0;
      for (int i = 0; i < DATA_BITS; i++) begin
         if (rd_bit_en[i]) begin
            rd_word[i] = mem[rd_offset + 12'(i)];
         end
      end
   end

   // Non-blocking update gives read-first behaviour when both ports hit the same word.
   always_ff @(posedge CLK) begin
      if (!RST && WCLKE && WE) begin
         for (int i = 0; i < DATA_BITS; i++) begin
            if (wr_bit_en[i]) begin
               mem[wr_offset + 12'(i)] <= WDATA[i];
            end
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         RDATA <= '0;
      end else if (RCLKE && RE) begin
         RDATA <= rd_word;
      end
   end

endmodule

// File: tb/tb_sb_ram40_4k_model.sv
// Scoreboard bench for sb_ram40_4k_model: a 16/16 instance with preloaded
// INIT_0 and a mixed-aspect instance (write x16, read x4).
module tb_sb_ram40_4k_model;

   typedef struct {
      string       tag;
      logic [15:0] exp;
      bit          onB;
   } sbEntry_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   logic [15:0] rdA, rdB;
   logic [10:0] raA = '0, waA = '0, raB = '0, waB = '0;
   logic [15:0] wdA = '0, mkA = '0, wdB = '0;
   logic        reA = 1'b0, rclkeA = 1'b0, weA = 1'b0, wclkeA = 1'b0;
   logic        reB = 1'b0, rclkeB = 1'b0, weB = 1'b0, wclkeB = 1'b0;

   logic [4095:0] modelA;
   logic [4095:0] modelB;
   sbEntry_t      sbQ[$];
   int            total = 0;
   int            bad   = 0;

   always #5 clk = ~clk;

   sb_ram40_4k_model #(.READ_MODE(0), .WRITE_MODE(0), .INIT_0(256'h1234)) dutA (
      .CLK(clk), .RST(rst), .RDATA(rdA), .RADDR(raA), .RCLKE(rclkeA), .RE(reA),
      .WDATA(wdA), .WADDR(waA), .WCLKE(wclkeA), .WE(weA), .MASK(mkA)
   );

   sb_ram40_4k_model #(.READ_MODE(2), .WRITE_MODE(0)) dutB (
      .CLK(clk), .RST(rst), .RDATA(rdB), .RADDR(raB), .RCLKE(rclkeB), .RE(reB),
      .WDATA(wdB), .WADDR(waB), .WCLKE(wclkeB), .WE(weB), .MASK(16'h0000)
   );

   function automatic logic [15:0] mRead(input logic [4095:0] m, input int mode, input logic [10:0] a);
      int w = 16 >> mode;
      int depth = 256 << mode;
      int base = (int'(a) % depth) * w;
      logic [15:0] r = '0;
      for (int i = 0; i < w; i++) r[i] = m[base + i];
      return r;
   endfunction

   function automatic logic [4095:0] mWrite(input logic [4095:0] m, input int mode, input logic [10:0] a,
                                            input logic [15:0] d, input logic [15:0] mk);
      int w = 16 >> mode;
      int depth = 256 << mode;
      int base = (int'(a) % depth) * w;
      for (int i = 0; i < w; i++) begin
         if (!(mode == 0 && mk[i])) m[base + i] = d[i];
      end
      return m;
   endfunction

   task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock: drive a port operation, queue the expected read, compare after the edge.
   task automatic applyStimulus(input bit onB, input bit ce, input bit we, input logic [10:0] wa,
                                input logic [15:0] wd, input logic [15:0] mk, input bit re,
                                input logic [10:0] ra, input string tag);
      sbEntry_t e;
      if (!onB) begin
         rclkeA = ce; wclkeA = ce; weA = we; waA = wa; wdA = wd; mkA = mk; reA = re; raA = ra;
         weB = 1'b0; reB = 1'b0;
      end else begin
         rclkeB = ce; wclkeB = ce; weB = we; waB = wa; wdB = wd; reB = re; raB = ra;
         weA = 1'b0; reA = 1'b0;
      end
      if (re && ce) begin
         e.tag = tag;
         e.onB = onB;
         e.exp = onB ? mRead(modelB, 2, ra) : mRead(modelA, 0, ra);
         sbQ.push_back(e);
      end
      if (we && ce) begin
         if (onB) modelB = mWrite(modelB, 0, wa, wd, 16'h0000);
         else     modelA = mWrite(modelA, 0, wa, wd, mk);
      end
      @(posedge clk);
      #1;
      if (re && ce) begin
         e = sbQ.pop_front();
         checkOutput(e.tag, e.onB ? rdB : rdA, e.exp);
      end
   endtask

   logic [10:0] rndAddr[12];

   initial begin
      modelA = '0;
      modelA[255:0] = 256'h1234;
      modelB = '0;

      // Asynchronous reset forces RDATA low with no clock edge and holds it while reads are requested.
      #2 rst = 1'b1;
      #1 checkOutput("rst_async", rdA, 16'h0000);
      reA = 1'b1; rclkeA = 1'b1; raA = 11'd0;
      repeat (2) @(posedge clk);
      #1 checkOutput("rst_hold", rdA, 16'h0000);
      @(negedge clk);
      rst = 1'b0;

      applyStimulus(0, 1, 0, 0, 0, 0, 1, 11'd0, "init_word0");
      applyStimulus(0, 1, 1, 11'h005, 16'hBEEF, 16'h0000, 0, 0, "wr_beef");
      applyStimulus(0, 1, 0, 0, 0, 0, 1, 11'h005, "rd_beef");
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 11'h000, "re_low");
      checkOutput("re_low_hold", rdA, 16'hBEEF);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 11'h000, "rclke_low");
      checkOutput("rclke_low_hold", rdA, 16'hBEEF);

      applyStimulus(0, 1, 1, 11'h007, 16'hFFFF, 16'h0000, 0, 0, "preload");
      applyStimulus(0, 1, 1, 11'h007, 16'h0000, 16'hFF00, 0, 0, "masked_wr");
      applyStimulus(0, 1, 0, 0, 0, 0, 1, 11'h007, "mask_rd");
      checkOutput("mask_const", rdA, 16'hFF00);

      applyStimulus(0, 1, 1, 11'h003, 16'h1111, 16'h0000, 0, 0, "wr_1111");
      applyStimulus(0, 1, 1, 11'h003, 16'h2222, 16'h0000, 1, 11'h003, "rdw_old");
      applyStimulus(0, 1, 0, 0, 0, 0, 1, 11'h003, "rdw_new");
      applyStimulus(0, 1, 0, 0, 0, 0, 1, 11'h705, "addr_wrap");

      for (int k = 0; k < 12; k++) begin
         rndAddr[k] = 11'($urandom_range(8, 255));
         applyStimulus(0, 1, 1, rndAddr[k], 16'($urandom), 16'($urandom), 0, 0, "rnd_wr");
      end
      for (int k = 0; k < 12; k++) begin
         applyStimulus(0, 1, 0, 0, 0, 0, 1, rndAddr[k] | 11'h300, $sformatf("rnd_rd%0d", k));
      end

      // Reset raised between edges of a read stream, with a write held pending across it.
      applyStimulus(0, 1, 0, 0, 0, 0, 1, 11'h005, "stream_a");
      applyStimulus(0, 1, 0, 0, 0, 0, 1, 11'h003, "stream_b");
      weA = 1'b1; waA = 11'h009; wdA = 16'h5555; mkA = 16'h0000;
      #2 rst = 1'b1;
      #1 checkOutput("rst_midstream", rdA, 16'h0000);
      @(posedge clk);
      #1 checkOutput("rst_mid_hold", rdA, 16'h0000);
      @(negedge clk);
      rst = 1'b0; weA = 1'b0;
      applyStimulus(0, 1, 0, 0, 0, 0, 1, 11'h009, "wr_dropped");
      applyStimulus(0, 1, 0, 0, 0, 0, 1, 11'h005, "survive_5");
      applyStimulus(0, 1, 0, 0, 0, 0, 1, 11'h003, "survive_3");

      // Mixed aspect: 16-bit write, 4-bit reads across the same bits.
      applyStimulus(1, 1, 1, 11'h000, 16'hABCD, 16'h0000, 0, 0, "mix_wr");
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1, 1, 0, 0, 0, 0, 1, 11'(k), $sformatf("mix_rd%0d", k));
      end
      checkOutput("mix_last_const", rdB, 16'h000A);
      applyStimulus(1, 1, 0, 0, 0, 0, 1, 11'h401, "mix_wrap");

      if (sbQ.size() != 0) begin
         checkOutput("sb_leftover", 16'(sbQ.size()), 16'h0000);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
